// File: rtl/dcache_mem_responder.sv
// rtl/dcache_mem_responder.sv - data-side cache request responder with programmable latency
//
// Purpose: responder end of the dcache request interface. Accepts one
// outstanding read or write, waits a programmable number of cycles
// (cached/uncached), then commits it against an internal word memory and
// pulses read_ok_o or write_ok_o for one cycle.
//
// Optional feature macro: RESP_LAT_JITTER_EN adds 0..3 random extra latency
// cycles from an 8-bit LFSR. Without it, latency is exactly the parameter value.
//
// Ports:
//   clock_i     in   1   system clock, rising edge
//   reset_i     in   1   asynchronous active-high reset
//   flush_i     in   1   aborts a request still counting down its latency
//   addr_i      in  32   byte address; word index = addr_i[DEPTH_LOG2+1:2]
//   ren_i       in   1   read request (single-cycle pulse allowed)
//   wen_i       in   4   byte write enables, held until write_ok_o
//   wdata_i     in  32   write data
//   ena_i       in   1   1 = cached latency, 0 = uncached latency
//   rdata_o     out 32   registered read data, held until the next read completes
//   read_ok_o   out  1   one-cycle read completion pulse
//   write_ok_o  out  1   one-cycle write completion pulse
//   busy_o      out  1   high while a request is in flight (BUSY or DONE)

module dcache_mem_responder #(
  parameter int DEPTH_LOG2   = 10,
  parameter int LAT_CACHED   = 1,
  parameter int LAT_UNCACHED = 4
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        flush_i,
  input  logic [31:0] addr_i,
  input  logic        ren_i,
  input  logic [3:0]  wen_i,
  input  logic [31:0] wdata_i,
  input  logic        ena_i,
  output logic [31:0] rdata_o,
  output logic        read_ok_o,
  output logic        write_ok_o,
  output logic        busy_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  // Wide enough for 255 plus up to 3 jitter cycles.
  localparam int CW = 10;
  localparam logic [CW-1:0] LAT_C = CW'(LAT_CACHED);
  localparam logic [CW-1:0] LAT_U = CW'(LAT_UNCACHED);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]            state;
  logic [CW-1:0]         cnt;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [3:0]            wen_q;
  logic [31:0]           wdata_q;
  logic                  rd_q;

  logic [31:0] mem [DEPTH];

  logic [DEPTH_LOG2-1:0] idx_in;
  logic                  accept;
  logic [CW-1:0]         lat_base;
  logic [CW-1:0]         lat_load;

  // Address bits outside the word index are ignored (aliasing and byte offset).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr_i[31:DEPTH_LOG2+2], addr_i[1:0]};

  assign idx_in   = addr_i[DEPTH_LOG2+1:2];
  assign accept   = (state == S_IDLE) && (ren_i || (wen_i != 4'b0000));
  assign lat_base = ena_i ? LAT_C : LAT_U;

`ifdef RESP_LAT_JITTER_EN
  logic [7:0] lfsr;

  // Fibonacci LFSR, taps 8,6,5,4; free-running every cycle.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      lfsr <= 8'hA5;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  assign lat_load = lat_base + {{(CW-2){1'b0}}, lfsr[1:0]};
`else
  assign lat_load = lat_base;
`endif

  // The commit happens on the edge that enters DONE. With zero latency that
  // edge is the accept edge itself, so the live inputs are used instead of
  // the (not yet loaded) latches.
  logic                  commit;
  logic                  c_rd;
  logic [DEPTH_LOG2-1:0] c_idx;
  logic [3:0]            c_wen;
  logic [31:0]           c_wdata;

  always_comb begin
    commit  = 1'b0;
    c_rd    = rd_q;
    c_idx   = idx_q;
    c_wen   = wen_q;
    c_wdata = wdata_q;
    if (state == S_IDLE) begin
      commit  = accept && (lat_load == '0);
      c_rd    = ren_i;
      c_idx   = idx_in;
      c_wen   = wen_i;
      c_wdata = wdata_i;
    end else if (state == S_BUSY) begin
      commit = !flush_i && (cnt == CW'(1));
    end
  end

  // Control path and registered read data.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state   <= S_IDLE;
      cnt     <= '0;
      idx_q   <= '0;
      wen_q   <= 4'b0000;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      rdata_o <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            idx_q   <= idx_in;
            wen_q   <= wen_i;
            wdata_q <= wdata_i;
            // Read wins when both are requested together.
            rd_q    <= ren_i;
            cnt     <= lat_load;
            state   <= (lat_load == '0) ? S_DONE : S_BUSY;
          end
        end
        S_BUSY: begin
          if (flush_i) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else if (cnt == CW'(1)) begin
            cnt   <= '0;
            state <= S_DONE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_DONE: begin
          // Always return to IDLE; a wen_i still held here is not sampled.
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase

      if (commit && c_rd) begin
        rdata_o <= mem[c_idx];
      end
    end
  end

  // Memory array has no reset; only written byte lanes change.
  always_ff @(posedge clock_i) begin
    if (commit && !c_rd) begin
      for (int k = 0; k < 4; k++) begin
        if (c_wen[k]) begin
          mem[c_idx][8*k +: 8] <= c_wdata[8*k +: 8];
        end
      end
    end
  end

  assign read_ok_o  = (state == S_DONE) && rd_q;
  assign write_ok_o = (state == S_DONE) && !rd_q;
  assign busy_o     = (state != S_IDLE);

endmodule

// File: tb/tb_dcache_mem_responder.sv
// tb/tb_dcache_mem_responder.sv - self-checking bench for dcache_mem_responder

module tb_dcache_mem_responder;

  logic        clock_i = 1'b0;
  logic        reset_i;
  logic        flush_i;
  logic [31:0] addr_i;
  logic        ren_i;
  logic [3:0]  wen_i;
  logic [31:0] wdata_i;
  logic        ena_i;
  logic [31:0] rdata_o;
  logic        read_ok_o;
  logic        write_ok_o;
  logic        busy_o;

  int passed = 0;
  int total  = 0;

  // Reference model: plain word array plus the expected rdata register.
  logic [31:0] model_mem [1024];
  logic [31:0] exp_rdata;

  always #5 clock_i = ~clock_i;

  dcache_mem_responder #(
    .DEPTH_LOG2  (10),
    .LAT_CACHED  (1),
    .LAT_UNCACHED(4)
  ) dut (
    .clock_i   (clock_i),
    .reset_i   (reset_i),
    .flush_i   (flush_i),
    .addr_i    (addr_i),
    .ren_i     (ren_i),
    .wen_i     (wen_i),
    .wdata_i   (wdata_i),
    .ena_i     (ena_i),
    .rdata_o   (rdata_o),
    .read_ok_o (read_ok_o),
    .write_ok_o(write_ok_o),
    .busy_o    (busy_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++) begin
      if (be[k]) r[8*k +: 8] = data[8*k +: 8];
    end
    return r;
  endfunction

  // Presents one request at the current cycle and follows it to completion.
  // Reads pulse ren_i for one cycle; writes hold wen_i through DONE.
  task automatic do_req(input bit is_read, input logic [31:0] addr, input logic [3:0] wen,
                        input logic [31:0] wdata, input bit ena, input string tag);
    int lat;
    int seen_k;
    int rd_pulses;
    int wr_pulses;
    int idx;
    lat = ena ? 1 : 4;
    seen_k = -1;
    rd_pulses = 0;
    wr_pulses = 0;
    idx = int'(addr[11:2]);
    addr_i = addr; ren_i = is_read; wen_i = wen; wdata_i = wdata; ena_i = ena;
    for (int k = 1; k <= lat + 2; k++) begin
      @(posedge clock_i); #1;
      if (k == 1) begin
        ren_i = 1'b0;
        if (is_read) wen_i = 4'b0000;
        // Changing inputs after acceptance must not affect the request.
        addr_i = $urandom; wdata_i = $urandom; ena_i = 1'($urandom);
      end
      if (read_ok_o)  rd_pulses++;
      if (write_ok_o) wr_pulses++;
      if ((read_ok_o || write_ok_o) && seen_k < 0) seen_k = k;
      if (k == lat + 2) wen_i = 4'b0000;
    end
    check({tag, "_lat"}, 32'(seen_k), 32'(lat + 1));
    check({tag, "_rdok"}, 32'(rd_pulses), is_read ? 32'd1 : 32'd0);
    check({tag, "_wrok"}, 32'(wr_pulses), is_read ? 32'd0 : 32'd1);
    check({tag, "_idle"}, {31'd0, busy_o}, 32'd0);
    if (is_read) begin
      exp_rdata = model_mem[idx];
    end else begin
      model_mem[idx] = merge(model_mem[idx], wdata, wen);
    end
    check({tag, "_rdata"}, rdata_o, exp_rdata);
  endtask

  // Issues a request, flushes it in its second BUSY cycle, and confirms nothing completes.
  task automatic flush_req(input bit is_read, input logic [31:0] addr, input logic [3:0] wen,
                           input logic [31:0] wdata, input string tag);
    int pulses;
    pulses = 0;
    addr_i = addr; ren_i = is_read; wen_i = wen; wdata_i = wdata; ena_i = 1'b0;
    @(posedge clock_i); #1;
    ren_i = 1'b0;
    @(posedge clock_i); #1;
    flush_i = 1'b1;
    @(posedge clock_i); #1;
    flush_i = 1'b0;
    wen_i = 4'b0000;
    check({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
    for (int k = 0; k < 8; k++) begin
      if (read_ok_o || write_ok_o) pulses++;
      @(posedge clock_i); #1;
    end
    check({tag, "_nook"}, 32'(pulses), 32'd0);
    check({tag, "_rdata"}, rdata_o, exp_rdata);
  endtask

  initial begin
    int pulses;
    logic [31:0] a;
    reset_i = 1'b1; flush_i = 1'b0; addr_i = '0; ren_i = 1'b0;
    wen_i = 4'b0000; wdata_i = '0; ena_i = 1'b1;
    exp_rdata = '0;
    #2;
    check("rst_rdata", rdata_o, 32'd0);
    check("rst_rdok", {31'd0, read_ok_o}, 32'd0);
    check("rst_wrok", {31'd0, write_ok_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    @(posedge clock_i); @(posedge clock_i); #1;
    reset_i = 1'b0;

    // Cached write then read.
    do_req(0, 32'h0000_0010, 4'b1111, 32'hDEAD_BEEF, 1, "wr10");
    do_req(1, 32'h0000_0010, 4'b0000, 32'h0, 1, "rd10");
    check("rd10_const", rdata_o, 32'hDEAD_BEEF);

    // Byte enables.
    do_req(0, 32'h0000_0020, 4'b1111, 32'h1122_3344, 1, "wr20");
    do_req(0, 32'h0000_0020, 4'b0101, 32'hAABB_CCDD, 1, "wr20be");
    do_req(1, 32'h0000_0020, 4'b0000, 32'h0, 1, "rd20");
    check("rd20_const", rdata_o, 32'h11BB_33DD);

    // Uncached latency and aliasing (0x1004 aliases word 1).
    do_req(0, 32'h0000_1004, 4'b1111, 32'h0000_0055, 0, "wr1004");
    do_req(1, 32'h0000_0004, 4'b0000, 32'h0, 0, "rd0004");
    check("rd0004_const", rdata_o, 32'h0000_0055);

    // Flush aborts of a read and a write.
    do_req(0, 32'h0000_0030, 4'b1111, 32'h0BAD_F00D, 1, "wr30");
    do_req(1, 32'h0000_0010, 4'b0000, 32'h0, 1, "rd10b");
    flush_req(1, 32'h0000_0030, 4'b0000, 32'h0, "flrd");
    flush_req(0, 32'h0000_0030, 4'b1111, 32'hFFFF_FFFF, "flwr");
    do_req(1, 32'h0000_0030, 4'b0000, 32'h0, 0, "rd30");
    check("rd30_const", rdata_o, 32'h0BAD_F00D);

    // Read wins over a simultaneous write; memory untouched.
    do_req(1, 32'h0000_0010, 4'b1111, 32'h1234_5678, 1, "prio");
    do_req(1, 32'h0000_0010, 4'b0000, 32'h0, 1, "prio_chk");
    check("prio_const", rdata_o, 32'hDEAD_BEEF);

    // Asynchronous reset with a read in flight.
    addr_i = 32'h0000_0020; ren_i = 1'b1; ena_i = 1'b0;
    @(posedge clock_i); #1;
    ren_i = 1'b0;
    #2 reset_i = 1'b1;
    #1;
    check("arst_busy", {31'd0, busy_o}, 32'd0);
    check("arst_rdata", rdata_o, 32'd0);
    check("arst_ok", {30'd0, read_ok_o, write_ok_o}, 32'd0);
    exp_rdata = '0;
    @(posedge clock_i); #1;
    reset_i = 1'b0;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      if (read_ok_o || write_ok_o) pulses++;
      @(posedge clock_i); #1;
    end
    check("arst_nook", 32'(pulses), 32'd0);
    do_req(1, 32'h0000_0020, 4'b0000, 32'h0, 1, "arst_next");

    // Randomized traffic over 16 words with random alias bits.
    for (int i = 0; i < 16; i++) begin
      a = {$urandom_range(0, 1023) << 12} | 32'(i << 2);
      do_req(0, a, 4'b1111, $urandom, 1'($urandom), "rinit");
    end
    for (int i = 0; i < 40; i++) begin
      a = {$urandom_range(0, 1023) << 12} | 32'($urandom_range(0, 15) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) begin
        do_req(1, a, 4'($urandom), 32'h0, 1'($urandom), "rrd");
      end else begin
        do_req(0, a, 4'($urandom_range(1, 15)), $urandom, 1'($urandom), "rwr");
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
